// File: rtl/arb3_rr_pkg.sv
// ---------------------------------------------------------------------------
// arb3_rr_pkg
//   Shared definitions for the three-way round-robin arbiter:
//     - state_t   : arbiter FSM encoding (IDLE / GRANT / TURN)
//     - NO_OWNER  : owner index reported when nobody holds the grant
//     - rr_next   : pointer/owner successor, modulo 3
//     - rr_pick   : round-robin search, first set request bit scanning
//                   ptr, ptr+1, ptr+2 (mod 3); NO_OWNER when req is zero
// ---------------------------------------------------------------------------
package arb3_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [1:0] NO_OWNER = 2'd3;

  // Successor index modulo 3; only meaningful for inputs 0..2.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Scan from the highest search offset down so the lowest offset with a
  // set bit is the one left in the result.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                         input logic [2:0] req);
    logic [1:0] idx;
    rr_pick = NO_OWNER;
    for (int k = 2; k >= 0; k--) begin
      idx = ptr;
      for (int s = 0; s < k; s++) idx = rr_next(idx);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/nor3_x1.sv
// ---------------------------------------------------------------------------
// nor3_x1
//   Behavioural view of the characterised 3-input NOR library cell.
//   Ports:
//     i0, i1, i2 : inputs
//     nq         : ~(i0 | i1 | i2)
// ---------------------------------------------------------------------------
module nor3_x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  output logic nq
);

  assign nq = ~(i0 | i1 | i2);

endmodule

// File: rtl/arb3_rr.sv
// ---------------------------------------------------------------------------
// arb3_rr
//   Round-robin arbiter sharing one downstream resource between three
//   requesters. The grant is registered, one-hot, and held while the owner
//   keeps its request high. Every handover passes through a one-cycle TURN
//   bubble with no grant. With MAX_HOLD != 0 an owner that has held the
//   grant for MAX_HOLD cycles is revoked as soon as another request is up.
//
//   Parameters:
//     MAX_HOLD : grant cycles before forced rotation (0 = never preempt)
//     HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
//   Ports:
//     ck      : clock, rising edge
//     rst     : synchronous active-high reset
//     req     : per-requester request, held for the whole ownership
//     gnt     : registered one-hot grant, zero when no owner
//     owner   : index of current owner, 3 when none
//     idle    : combinational, high when no request is raised
//     preempt : registered one-cycle pulse when the hold budget revokes gnt
// ---------------------------------------------------------------------------
module arb3_rr
  import arb3_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       ck,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] owner,
  output logic       idle,
  output logic       preempt
);

  localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  state_t            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic [1:0]        pick;
  logic              owner_req;
  logic              others_req;
  logic              budget_hit;

  nor3_x1 u_idle (
    .i0 (req[0]),
    .i1 (req[1]),
    .i2 (req[2]),
    .nq (idle)
  );

  assign pick       = rr_pick(ptr_q, req);
  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  // ">=" rather than "==": once the budget is spent with nobody waiting the
  // counter keeps climbing, and the first later contender must still win.
  assign budget_hit = PREEMPT_EN && (hold_q >= HOLD_LAST);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    unique case (state_q)
      // TURN exists only to force the empty-grant bubble; after it the
      // arbiter decides exactly as in IDLE.
      ST_IDLE, ST_TURN: begin
        if (pick != NO_OWNER) begin
          state_d = ST_GRANT;
          owner_d = pick;
          gnt_d   = 3'b001 << pick;
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
          owner_d = NO_OWNER;
          gnt_d   = 3'b000;
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          // Release wins over a coinciding budget expiry.
          state_d = ST_TURN;
          owner_d = NO_OWNER;
          gnt_d   = 3'b000;
          ptr_d   = rr_next(owner_q);
        end else if (budget_hit && others_req) begin
          state_d   = ST_TURN;
          owner_d   = NO_OWNER;
          gnt_d     = 3'b000;
          ptr_d     = rr_next(owner_q);
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = NO_OWNER;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 3'b000;
      owner_q   <= NO_OWNER;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign preempt = preempt_q;

endmodule
